slfifo_wr_arbiter: RTL and testbench
====================================

Name: slfifo_wr_arbiter

Overview:
Round-robin scheduler that shares the FX3 slave-FIFO write path (GPIF-II, 32-bit, synchronous) between NUM_CH on-FPGA producer FIFOs, e.g. hydrophone ADC channel buffers. It selects a channel and drives faddr to that channel's socket. It waits for address/flag settling, then bursts words from the granted FIFO into FX3 with slwr_/pktend_. It sits between the producer FIFOs and the fdata tri-state pad logic at top level.

Parameters:
NUM_CH, 4, number of requesters; channel i maps to faddr = i (NUM_CH ≤ 4).
BURST_WORDS, 1024, max 32-bit words per grant (4 KB FX3 buffer).
SETTLE_CYC, 3, cycles after faddr change before flags are trusted.
GAP_CYC, 2, idle cycles after each burst before the next arbitration.

Ports:
clk_100  in  1  100 MHz interface clock.
reset_  in  1  Reset: asynchronous, active-low.
enable  in  1  Arbitration enable; sampled in IDLE and WRITE.
ch_empty  in  NUM_CH  Per-channel show-ahead FIFO empty.
ch_data  in  32*NUM_CH  Per-channel head word; channel i occupies bits [32i+31:32i].
ch_last  in  NUM_CH  Head word is the last word of a packet.
ch_pop  out  NUM_CH  One-hot pop strobe to the granted FIFO.
flaga  in  1  FX3 current-thread not-full (1 = space available); raw pin.
flagb  in  1  FX3 current-thread partial flag (1 = above watermark); raw pin.
faddr  out  2  FX3 socket address.
slwr_  out  1  FX3 write strobe, active low.
pktend_  out  1  FX3 packet end, active low.
fdata_out  out  32  Write data to the pad.
fdata_oe  out  1  Pad output enable.
busy  out  1  High in any state other than IDLE.
grant_ch  out  2  Currently or last granted channel.

Behaviour:
- Reset (async, immediate, including mid-burst): state IDLE, ch_pop=0, slwr_=1, pktend_=1, fdata_oe=0, fdata_out=0, faddr=0, grant_ch=0, busy=0, rr pointer=0, counters=0.
- flaga/flagb are flopped once (flaga_d/flagb_d); all decisions use the flopped values.
- States: IDLE, SETTLE, WAIT_FLAG, WRITE, GAP.
- IDLE: if enable=1 and any ch_empty[i]=0, grant the first non-empty channel searching from rr_ptr upward with wrap. Register grant_ch and faddr, load settle_cnt=SETTLE_CYC-1, go to SETTLE. Otherwise stay.
- SETTLE: decrement settle_cnt; at 0 go to WAIT_FLAG.
- WAIT_FLAG: flaga_d=1 and flagb_d=1 -> WRITE, clear word_cnt. Otherwise wait with no timeout.
- WRITE: ch_pop[g] = ~ch_empty[g] & flagb_d & enable & (word_cnt<BURST_WORDS) & ~last_sent.
  - Each pop increments word_cnt.
  - Pop with ch_last[g]=1 sets last_sent.
- WRITE exits to GAP the cycle after any pop condition term is false. Pops already issued still complete.
- Output pipeline, one register stage:
  - A pop at cycle t gives slwr_=0 at t+1, with fdata_out = that word and pktend_ = ~ch_last[g] sampled at t.
  - fdata_oe = ~slwr_ on the same cycle.
  - Pop latency is 1 cycle. Flag-to-stop latency is ≤3 writes past the watermark; FX3 watermark must be set ≥4.
- GAP: hold slwr_=1 for GAP_CYC cycles. Set rr_ptr = grant_ch+1 (mod NUM_CH), then go to IDLE.
- Boundaries:
  - ch_empty rising mid-burst ends the grant; no zero-length packet and no pktend is issued.
  - word_cnt==BURST_WORDS ends the grant without pktend; FX3 auto-commits the full buffer.
  - ch_last on word BURST_WORDS gives both pktend_=0 and burst end on the same write.
  - enable falling during WRITE stops popping next cycle and goes to GAP; it has no effect in SETTLE/WAIT_FLAG.
  - flaga_d=0 during WRITE is ignored; flagb governs.
  - Single requester: that channel is re-granted after GAP.

Test Plan:
- Channels 0 and 2 each hold 8 words, none last, flags high -> grant 0: faddr=0 and 8 consecutive slwr_=0 starting SETTLE_CYC+2 cycles after grant. Then GAP of 2 cycles, then grant 2 with faddr=2 and 8 writes. pktend_ stays 1 throughout.
- Channel 1 holds 5 words with ch_last on word 5 -> exactly 5 writes, pktend_=0 coincident with the 5th slwr_=0, data matches FIFO order.
- Channel 0 has 2000 words, flags high -> 1024 writes, GAP, re-grant 0, remaining 976 writes.
- flagb drops after write 100 -> pops stop within 2 cycles, at most 103 slwr_ pulses, state GAP. With flagb held low, the next grant waits in WAIT_FLAG with no writes.
- All 4 channels non-empty (1 word each) with rr_ptr=3 -> grant order 3,0,1,2.
- Assert reset_ low mid-WRITE -> same-cycle slwr_=1, fdata_oe=0, ch_pop=0. After release, state IDLE with rr_ptr=0.

Source files
------------

// File: rtl/slfifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// slfifo_wr_arbiter_if
// Bundles the producer-FIFO side and the FX3 slave-FIFO write side of the
// write arbiter.
//   ch_empty/ch_data/ch_last : per-channel show-ahead FIFO head (32 bits/ch)
//   ch_pop                   : one-hot pop strobe back to the FIFOs
//   flaga/flagb              : raw FX3 thread flags
//   faddr/slwr_/pktend_      : FX3 socket address, write strobe, packet end
//   fdata_out/fdata_oe       : write data and output enable to the pad
// master = arbiter, slave = producers + FX3 pad environment.
// ---------------------------------------------------------------------------
interface slfifo_wr_arbiter_if #(
    parameter int NUM_CH = 4
) ();
    logic [NUM_CH-1:0]    ch_empty;
    logic [32*NUM_CH-1:0] ch_data;
    logic [NUM_CH-1:0]    ch_last;
    logic [NUM_CH-1:0]    ch_pop;
    logic                 flaga;
    logic                 flagb;
    logic [1:0]           faddr;
    logic                 slwr_;
    logic                 pktend_;
    logic [31:0]          fdata_out;
    logic                 fdata_oe;

    modport master (
        input  ch_empty, ch_data, ch_last, flaga, flagb,
        output ch_pop, faddr, slwr_, pktend_, fdata_out, fdata_oe
    );

    modport slave (
        output ch_empty, ch_data, ch_last, flaga, flagb,
        input  ch_pop, faddr, slwr_, pktend_, fdata_out, fdata_oe
    );
endinterface

// File: rtl/slfifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// slfifo_wr_arbiter
// Round-robin scheduler sharing the FX3 slave-FIFO write path between
// NUM_CH producer FIFOs. A granted channel gets faddr, a settle period, a
// wait for the partial flag, then a burst of up to BURST_WORDS writes.
// Ports:
//   clk_100   : interface clock
//   reset_    : asynchronous active-low reset
//   enable    : arbitration enable (honoured in IDLE and WRITE)
//   busy      : high whenever the FSM is not in IDLE
//   grant_ch  : current / last granted channel
//   bus       : producer FIFOs + FX3 write pins (master modport)
// ---------------------------------------------------------------------------
module slfifo_wr_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int BURST_WORDS = 1024,
    parameter int SETTLE_CYC  = 3,
    parameter int GAP_CYC     = 2
) (
    input  logic                clk_100,
    input  logic                reset_,
    input  logic                enable,
    output logic                busy,
    output logic [1:0]          grant_ch,
    slfifo_wr_arbiter_if.master bus
);
    localparam int WCW = $clog2(BURST_WORDS + 1);
    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int GCW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {IDLE, SETTLE, WAIT_FLAG, WRITE, GAP} state_t;

    state_t              state, state_nx;
    logic                flaga_d, flagb_d;
    logic [1:0]          rr_ptr;
    logic [WCW-1:0]      word_cnt;
    logic [SCW-1:0]      settle_cnt;
    logic [GCW-1:0]      gap_cnt;
    logic                last_sent;
    logic                req_any;
    logic [1:0]          pick;
    logic [2*NUM_CH-1:0] req_rot;
    logic                sel_empty, sel_last;
    logic [31:0]         sel_data;
    logic                pop_ok;

    // Rotate the request vector so bit 0 is rr_ptr; the lowest set bit is
    // the first requester at or above the pointer, with wrap.
    always_comb begin
        req_rot = {~bus.ch_empty, ~bus.ch_empty} >> rr_ptr;
        req_any = 1'b0;
        pick    = rr_ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                req_any = 1'b1;
                pick    = 2'((32'(rr_ptr) + 32'(k)) % NUM_CH);
            end
        end
    end

    // Head of the granted FIFO
    always_comb begin
        sel_empty = 1'b1;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_ch == 2'(k)) begin
                sel_empty = bus.ch_empty[k];
                sel_last  = bus.ch_last[k];
                sel_data  = bus.ch_data[32*k +: 32];
            end
        end
    end

    // State register
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) state <= IDLE;
        else         state <= state_nx;
    end

    // Next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (enable && req_any)   state_nx = SETTLE;
            SETTLE:    if (settle_cnt == '0)    state_nx = WAIT_FLAG;
            WAIT_FLAG: if (flaga_d && flagb_d)  state_nx = WRITE;
            WRITE:     if (!pop_ok)             state_nx = GAP;
            GAP:       if (gap_cnt == '0)       state_nx = IDLE;
            default:                            state_nx = IDLE;
        endcase
    end

    // FSM outputs. flaga is deliberately not in the pop term: once writing,
    // the partial flag alone throttles the burst.
    always_comb begin
        busy   = (state != IDLE);
        pop_ok = (state == WRITE) && !sel_empty && flagb_d && enable &&
                 (word_cnt < WCW'(BURST_WORDS)) && !last_sent;
        bus.ch_pop = '0;
        for (int k = 0; k < NUM_CH; k++)
            bus.ch_pop[k] = pop_ok && (grant_ch == 2'(k));
    end

    // Grant, counters and flag synchronisers
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            flaga_d    <= 1'b0;
            flagb_d    <= 1'b0;
            grant_ch   <= '0;
            bus.faddr  <= '0;
            rr_ptr     <= '0;
            settle_cnt <= '0;
            gap_cnt    <= '0;
            word_cnt   <= '0;
            last_sent  <= 1'b0;
        end else begin
            flaga_d <= bus.flaga;
            flagb_d <= bus.flagb;
            case (state)
                IDLE: if (state_nx == SETTLE) begin
                    grant_ch   <= pick;
                    bus.faddr  <= pick;
                    settle_cnt <= SCW'(SETTLE_CYC - 1);
                end
                SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                WAIT_FLAG: begin
                    word_cnt  <= '0;
                    last_sent <= 1'b0;
                end
                WRITE: begin
                    if (pop_ok) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (sel_last) last_sent <= 1'b1;
                    end else begin
                        gap_cnt <= GCW'(GAP_CYC - 1);
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) rr_ptr  <= 2'((32'(grant_ch) + 32'd1) % NUM_CH);
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // One-stage output pipeline: the word popped this cycle is written next.
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            bus.slwr_     <= 1'b1;
            bus.pktend_   <= 1'b1;
            bus.fdata_oe  <= 1'b0;
            bus.fdata_out <= '0;
        end else begin
            bus.slwr_    <= ~pop_ok;
            bus.pktend_  <= ~(pop_ok & sel_last);
            bus.fdata_oe <= pop_ok;
            if (pop_ok) bus.fdata_out <= sel_data;
        end
    end
endmodule

// File: tb/tb_slfifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_slfifo_wr_arbiter
// Producer FIFOs are modelled as queues; each load also pushes the expected
// FX3 writes (data, socket, pktend_) and expected burst lengths. A monitor
// checks every slwr_ strobe and every burst length against those queues.
// ---------------------------------------------------------------------------
module tb_slfifo_wr_arbiter;
    localparam int NUM_CH = 4;

    logic       clk_100 = 1'b0;
    logic       reset_;
    logic       enable;
    logic       busy;
    logic [1:0] grant_ch;

    slfifo_wr_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

    slfifo_wr_arbiter #(
        .NUM_CH(NUM_CH), .BURST_WORDS(1024), .SETTLE_CYC(3), .GAP_CYC(2)
    ) dut (
        .clk_100 (clk_100),
        .reset_  (reset_),
        .enable  (enable),
        .busy    (busy),
        .grant_ch(grant_ch),
        .bus     (bus.master)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  addr;
        logic        pkt;
    } wr_t;

    typedef struct {
        int lo;
        int hi;
    } br_t;

    logic [32:0] fq [NUM_CH][$];   // {last, data}
    wr_t         exp_q[$];
    br_t         exp_b[$];
    int          n_chk    = 0;
    int          n_pass   = 0;
    int          wr_total = 0;
    int          run      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic fail(input string name, input int act);
        n_chk++;
        $display("FAIL %s: got %0d required none", name, act);
    endtask

    task automatic refresh();
        logic [32:0] h;
        for (int i = 0; i < NUM_CH; i++) begin
            h = '0;
            if (fq[i].size() != 0) h = fq[i][0];
            bus.ch_empty[i]          = (fq[i].size() == 0);
            bus.ch_data[32*i +: 32]  = h[31:0];
            bus.ch_last[i]           = h[32];
        end
    endtask

    // Producer FIFO model: advance on the pop seen at the edge
    always @(posedge clk_100) begin
        logic [NUM_CH-1:0] p;
        p = bus.ch_pop;
        #1;
        for (int i = 0; i < NUM_CH; i++)
            if (p[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        refresh();
    end

    // Monitor / scoreboard
    always @(negedge clk_100) begin
        wr_t e;
        br_t b;
        if (!reset_) begin
            run = 0;
        end else if (!bus.slwr_) begin
            wr_total++;
            run++;
            if (exp_q.size() == 0) begin
                fail("unexpected_write", int'(bus.fdata_out));
            end else begin
                e = exp_q.pop_front();
                chk("fdata_out", 64'(bus.fdata_out), 64'(e.data));
                chk("faddr",     64'(bus.faddr),     64'(e.addr));
                chk("grant_ch",  64'(grant_ch),      64'(e.addr));
                chk("pktend_",   64'(bus.pktend_),   64'(e.pkt));
                chk("fdata_oe",  64'(bus.fdata_oe),  64'd1);
            end
        end else if (run > 0) begin
            if (exp_b.size() == 0) begin
                fail("unexpected_burst", run);
            end else begin
                b = exp_b.pop_front();
                n_chk++;
                if (run >= b.lo && run <= b.hi) n_pass++;
                else $display("FAIL burst_len: got %0d required %0d..%0d", run, b.lo, b.hi);
            end
            run = 0;
        end
    end

    // Fill channel ch with n words base+1..base+n; word last_at carries ch_last
    task automatic load(input int ch, input int n, input logic [31:0] base, input int last_at);
        for (int i = 1; i <= n; i++) begin
            logic lst;
            lst = (i == last_at);
            fq[ch].push_back({lst, base + 32'(i)});
            exp_q.push_back('{data: base + 32'(i), addr: 2'(ch), pkt: ~lst});
        end
    endtask

    task automatic burst(input int lo, input int hi);
        exp_b.push_back('{lo, hi});
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c;
        c = 0;
        repeat (3) @(negedge clk_100);
        while ((exp_q.size() != 0 || exp_b.size() != 0 || busy || run != 0) && c < budget) begin
            @(negedge clk_100); #1;
            c++;
        end
        n_chk++;
        if (c < budget) n_pass++;
        else $display("FAIL %s: timeout after %0d cycles, %0d writes outstanding", name, c, exp_q.size());
    endtask

    task automatic wait_wr(input string name, input int target, input int budget);
        int c;
        c = 0;
        while (wr_total < target && c < budget) begin
            @(negedge clk_100); #1;
            c++;
        end
        n_chk++;
        if (wr_total >= target) n_pass++;
        else $display("FAIL %s: got %0d writes required %0d", name, wr_total, target);
    endtask

    initial begin
        int c, w;
        reset_    = 1'b0;
        enable    = 1'b1;
        bus.flaga = 1'b1;
        bus.flagb = 1'b1;
        repeat (3) @(negedge clk_100);
        chk("rst_slwr_",    64'(bus.slwr_),     64'd1);
        chk("rst_pktend_",  64'(bus.pktend_),   64'd1);
        chk("rst_fdata_oe", 64'(bus.fdata_oe),  64'd0);
        chk("rst_fdata",    64'(bus.fdata_out), 64'd0);
        chk("rst_ch_pop",   64'(bus.ch_pop),    64'd0);
        chk("rst_faddr",    64'(bus.faddr),     64'd0);
        chk("rst_grant",    64'(grant_ch),      64'd0);
        chk("rst_busy",     64'(busy),          64'd0);
        reset_ = 1'b1;

        // Two requesters, rr_ptr=0: ch0 then ch2, 8 words each, no pktend
        load(0, 8, 32'h1000_0000, 0); burst(8, 8);
        load(2, 8, 32'h2000_0000, 0); burst(8, 8);
        c = 0;
        while (!busy && c < 10) begin @(negedge clk_100); #1; c++; end
        c = 0;
        while (bus.slwr_ && c < 20) begin @(negedge clk_100); #1; c++; end
        chk("first_write_latency", 64'(c), 64'd5);
        wait_idle("two_ch", 200);

        // ch1: last on word 5 stops the burst; leftover 2 words re-granted
        load(1, 7, 32'hA5A5_0000, 5); burst(5, 5); burst(2, 2);
        wait_idle("pkt_last", 200);

        // ch0: 2000 words, last on word 1024 coincides with burst limit
        load(0, 2000, 32'h3000_0000, 1024); burst(1024, 1024); burst(976, 976);
        wait_idle("long_burst", 5000);

        // flagb drop after write 100 stops the burst; re-grant parks in WAIT_FLAG
        load(3, 200, 32'h4000_0000, 0); burst(100, 103); burst(97, 100);
        w = wr_total;
        wait_wr("flagb_reach100", w + 100, 400);
        bus.flagb = 1'b0;
        repeat (10) @(negedge clk_100);
        #1 w = wr_total;
        repeat (40) @(negedge clk_100);
        #1;
        chk("flagb_low_no_write", 64'(wr_total), 64'(w));
        chk("flagb_low_busy",     64'(busy),     64'd1);
        bus.flagb = 1'b1;
        wait_idle("flagb_resume", 500);

        // enable drop mid-burst: stop, idle while disabled, resume later
        load(1, 20, 32'h5000_0000, 0); burst(5, 8); burst(12, 15);
        w = wr_total;
        wait_wr("enable_reach5", w + 5, 100);
        enable = 1'b0;
        repeat (30) @(negedge clk_100);
        #1 w = wr_total;
        repeat (10) @(negedge clk_100);
        #1;
        chk("disabled_no_write", 64'(wr_total), 64'(w));
        chk("disabled_busy",     64'(busy),     64'd0);
        enable = 1'b1;
        wait_idle("enable_resume", 300);

        // rr_ptr is 2 here; one word on ch2 moves it to 3, then 3,0,1,2
        load(2, 1, 32'h6000_0000, 0); burst(1, 1);
        wait_idle("rr_setup", 100);
        load(3, 1, 32'h7000_0003, 1); burst(1, 1);
        load(0, 1, 32'h7000_0000, 1); burst(1, 1);
        load(1, 1, 32'h7000_0001, 1); burst(1, 1);
        load(2, 1, 32'h7000_0002, 1); burst(1, 1);
        wait_idle("rr_order", 200);

        // Reset mid-WRITE
        load(0, 50, 32'h8000_0000, 0);
        w = wr_total;
        wait_wr("pre_reset_writes", w + 10, 100);
        reset_ = 1'b0;
        #1;
        chk("mid_rst_slwr_",    64'(bus.slwr_),    64'd1);
        chk("mid_rst_fdata_oe", 64'(bus.fdata_oe), 64'd0);
        chk("mid_rst_ch_pop",   64'(bus.ch_pop),   64'd0);
        chk("mid_rst_busy",     64'(busy),         64'd0);
        for (int i = 0; i < NUM_CH; i++) fq[i].delete();
        exp_q.delete();
        exp_b.delete();
        repeat (3) @(negedge clk_100);
        reset_ = 1'b1;
        // rr_ptr back at 0 -> ch1 wins over ch3
        load(1, 3, 32'h9000_0001, 0); burst(3, 3);
        load(3, 3, 32'h9000_0003, 0); burst(3, 3);
        wait_idle("post_reset", 200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
